uart_rx: RTL

- 8N1 UART receiver. It is the receive-side counterpart of uart_tx and uses the same runtime Baud_Rate input convention.
- Samples UART_RXD with 16x oversampling and majority-free mid-bit sampling, assembling bytes LSB first.
- Presents each byte in a holding register with a ready/read handshake, plus framing-error and overrun flags.
- Sits between the pad-side serial input and the host register interface.

---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled mid-bit sampling driven by a fractional
// baud accumulator, with a ready/read holding register and sticky error flags.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] Baud_Rate,
  input  logic        UART_RXD,
  input  logic        UART_RX_RD,
  output logic [7:0]  UART_RxREG,
  output logic        UART_RX_RDY,
  output logic        UART_RX_BUSY,
  output logic        UART_FERR,
  output logic        UART_OVR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [31:0] CLK_FREQ_W = 32'(CLK_FREQ);

  state_t      state;
  state_t      state_nxt;
  logic        rxd_meta;
  logic        rxs;
  logic [31:0] acc;
  logic [31:0] acc_sum;
  logic [31:0] baud_inc;
  logic        tick;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        start_mid;
  logic        bit_mid;
  logic        enter_start;
  logic        shift_en;
  logic        frame_ok;
  logic        frame_bad;

  // Stage: two-flop synchronizer; the line idles high so the flops reset to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= UART_RXD;
      rxs      <= rxd_meta;
    end
  end

  // Stage: fractional tick generator, 16 ticks per bit on average
  assign baud_inc = {11'd0, Baud_Rate, 4'd0};
  assign acc_sum  = acc + baud_inc;
  assign tick     = (acc_sum >= CLK_FREQ_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= 32'd0;
    end else if (enter_start) begin
      acc <= 32'd0;
    end else if (tick) begin
      acc <= acc_sum - CLK_FREQ_W;
    end else begin
      acc <= acc_sum;
    end
  end

  assign start_mid = (state == S_START) && tick && (os_cnt == 4'd7);
  assign bit_mid   = ((state == S_DATA) || (state == S_STOP)) && tick && (os_cnt == 4'd15);

  // Stage: frame state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rxs && (Baud_Rate != 17'd0)) state_nxt = S_START;
      S_START: if (start_mid) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (bit_mid && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (bit_mid) state_nxt = rxs ? S_IDLE : S_BREAK;
      S_BREAK: if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enter_start = 1'b0;
    shift_en    = 1'b0;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      S_IDLE:  enter_start = (state_nxt == S_START);
      S_DATA:  shift_en    = bit_mid;
      S_STOP: begin
        frame_ok  = bit_mid && rxs;
        frame_bad = bit_mid && !rxs;
      end
      default: ;
    endcase
  end

  // os_cnt restarts on every state change so each state measures its own ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt  <= 4'd0;
      bit_cnt <= 3'd0;
    end else begin
      if (state_nxt != state) begin
        os_cnt <= 4'd0;
      end else if (tick && (state != S_IDLE)) begin
        os_cnt <= os_cnt + 4'd1;
      end
      if (state == S_START) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Stage: data shift register (right shift, so the first bit ends up in bit 0)
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift_reg <= {rxs, shift_reg[7:1]};
    end
  end

  // Stage: host-side holding register; a completing frame beats a coincident read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      UART_RxREG  <= 8'h00;
      UART_RX_RDY <= 1'b0;
      UART_FERR   <= 1'b0;
      UART_OVR    <= 1'b0;
    end else begin
      if (frame_ok && (!UART_RX_RDY || UART_RX_RD)) begin
        UART_RxREG <= shift_reg;
      end

      if (frame_ok) begin
        UART_RX_RDY <= 1'b1;
      end else if (UART_RX_RD) begin
        UART_RX_RDY <= 1'b0;
      end

      if (frame_ok && UART_RX_RDY && !UART_RX_RD) begin
        UART_OVR <= 1'b1;
      end else if (UART_RX_RD) begin
        UART_OVR <= 1'b0;
      end

      if (frame_bad) begin
        UART_FERR <= 1'b1;
      end else if (UART_RX_RD) begin
        UART_FERR <= 1'b0;
      end
    end
  end

  assign UART_RX_BUSY = (state != S_IDLE);

endmodule
